beam_thresh_sequencer: RTL
==========================

// Module: beam_thresh_sequencer
// PURPOSE
//  Owns the threshold path of the beamform trigger. Holds per-beam, per-set thresholds in a staging RAM and
//  serially shifts them into the cascaded threshold chain of the dual-beam cores (thresh_o/thresh_wr_o).
//  It then pulses thresh_update_o so that every beam swaps to the new values in the same cycle.
//  Sits between the register interface and the beamform trigger; it is the only driver of its thresh_* inputs.
// PARAMETERS
//  NBEAMS       48        beams in the trigger; NSLOT = NBEAMS rounded up to even = chain length per set
//  TBITS        18        threshold width per set (fixed by beam cores)
//  INIT_THRESH  18'h3FFFF value written to every RAM slot after reset, then auto-loaded (no-trigger default)
//  AW           $clog2(NSLOT) staging RAM address width (derived)
// PORTS
//  clk_i            in   1        trigger-domain clock
//  rst_n_i          in   1        async active-low reset
//  cfg_wr_i         in   1        staging RAM write strobe
//  cfg_set_i        in   1        threshold set (0/1) for cfg_wr_i
//  cfg_addr_i       in   AW       beam slot for cfg_wr_i
//  cfg_data_i       in   TBITS    threshold value
//  cfg_load_i       in   2        per-set load request (level sampled in IDLE)
//  busy_o           out  1        sequence (INIT/READ/SHIFT/UPD) in progress
//  done_o           out  2        one-cycle pulse per set, coincident with its update pulse
//  cfg_err_o        out  1        sticky: write dropped (set busy or addr>=NSLOT); cleared only by reset
//  thresh_o         out  2*TBITS  chain data, set k on [k*TBITS +: TBITS]
//  thresh_wr_o      out  2        per-set chain shift strobe
//  thresh_update_o  out  2        per-set commit pulse
// BEHAVIOUR
//  Reset: all outputs 0 except busy_o=1; FSM enters INIT. RAM is not reset; INIT overwrites it.
//  States: INIT -> READ -> SHIFT -> UPD -> IDLE; IDLE -> READ when active mask != 0.
//  INIT: NSLOT cycles, writes INIT_THRESH to both sets, slots 0..NSLOT-1; then active mask = 2'b11 -> READ.
//  IDLE: active mask <= cfg_load_i | pending; pending cleared. busy_o=0.
//  READ (1 cyc): RAM addr = NSLOT-1; 1-cycle registered read latency.
//  SHIFT (NSLOT cyc): on cycle j (0..NSLOT-1), thresh_wr_o[k]=1 for active k and thresh_o[k] = RAM[k][NSLOT-1-j].
//   Slot NSLOT-1 enters first, so slot s ends at beam s. Inactive sets: wr=0, their chain is untouched.
//  UPD (1 cyc): thresh_update_o = active mask, done_o = active mask; next IDLE.
//  Latency: cfg_load_i high in IDLE cycle N -> first wr N+2, last wr N+1+NSLOT, update/done N+2+NSLOT.
//  thresh_o = 0 whenever thresh_wr_o is low for that set (no stale data on the bus).
//  cfg_load_i outside IDLE: OR'd into pending and served on the next IDLE pass (one cycle in IDLE).
//   A request for a set that is currently active is still pended (reload), never merged.
//  cfg_wr_i: writes RAM[cfg_set_i][cfg_addr_i] at the clock edge when accepted.
//   Dropped, and cfg_err_o set, if in INIT, if cfg_set_i is in the active mask (READ/SHIFT/UPD), or if addr>=NSLOT.
//   Writes to the inactive set during a load are accepted.
//  Simultaneous cfg_wr_i and cfg_load_i in IDLE to the same slot: the write lands first; the load reads the new value.
//  Padding slot (NBEAMS odd, slot NSLOT-1) is shifted like any other slot; its value is don't-care to the cores.
//  Reset mid-sequence: outputs 0 immediately (async); restarts INIT; partially shifted chain is overwritten
//   by the INIT auto-load before any update pulse.
//  Never asserts thresh_wr_o and thresh_update_o for the same set in the same cycle.
// TESTING  (NBEAMS=5 -> NSLOT=6 unless noted)
//  1 Reset release -> busy 6 INIT cycles; 6 wr on both sets, all 3FFFF; update/done=2'b11 once; busy_o falls.
//  2 Write set0 slot s = s+100, cfg_load_i=2'b01 -> wr[0] sequence 105,104..100; wr[1] stays 0; update=01 at N+8.
//  3 cfg_load_i=2'b10 during a set0 SHIFT -> set1 load starts 2 cycles after set0 UPD; done_o=01 then 10.
//  4 cfg_wr_i to set0 during set0 SHIFT -> dropped, cfg_err_o=1; set1 write accepted, read back by next set1 load.
//  5 cfg_addr_i=6 -> dropped, cfg_err_o=1; RAM unchanged (verified by a full load of that set).
//  6 rst_n_i low at SHIFT cycle 3 -> outputs 0 that cycle, INIT reruns, chain model equals all 3FFFF after update.

Source files
------------

// File: rtl/beam_thresh_sequencer.sv
// Staging RAM for per-beam trigger thresholds (two sets) and the serial loader that
// shifts them into the beam-core threshold chain, then commits them with one update pulse.
module beam_thresh_sequencer #(
   parameter int unsigned      NBEAMS      = 48,
   parameter int unsigned      TBITS       = 18,
   parameter logic [TBITS-1:0] INIT_THRESH = {TBITS{1'b1}},
   localparam int unsigned     NSLOT       = NBEAMS + (NBEAMS % 2),
   localparam int unsigned     AW          = (NSLOT > 2) ? $clog2(NSLOT) : 1
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               cfg_wr_i,
   input  logic               cfg_set_i,
   input  logic [AW-1:0]      cfg_addr_i,
   input  logic [TBITS-1:0]   cfg_data_i,
   input  logic [1:0]         cfg_load_i,
   output logic               busy_o,
   output logic [1:0]         done_o,
   output logic               cfg_err_o,
   output logic [2*TBITS-1:0] thresh_o,
   output logic [1:0]         thresh_wr_o,
   output logic [1:0]         thresh_update_o
);

   typedef enum logic [2:0] {
      ST_INIT,
      ST_READ,
      ST_SHIFT,
      ST_UPD,
      ST_IDLE
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [AW-1:0]      r_cnt, w_cnt_nxt;
   logic               r_drain, w_drain_nxt;
   logic [1:0]         r_active, w_active_nxt;
   logic [1:0]         r_pend, w_pend_nxt;
   logic               w_rd_en;

   logic               r_busy, w_busy_nxt;
   logic [1:0]         r_done, w_done_nxt;
   logic               r_err, w_err_nxt;
   logic [2*TBITS-1:0] r_thresh, w_thresh_nxt;
   logic [1:0]         r_wr, w_wr_nxt;
   logic [1:0]         r_upd, w_upd_nxt;

   logic               w_addr_ok;
   logic               w_set_locked;
   logic               w_cfg_ok;

   logic [TBITS-1:0]   r_ram [2][NSLOT];

   // Write acceptance: never during INIT, never into a set being shifted, never past the chain.
   always_comb begin
      w_addr_ok    = (32'(cfg_addr_i) < NSLOT);
      w_set_locked = ((r_state == ST_READ) || (r_state == ST_SHIFT) || (r_state == ST_UPD))
                     && r_active[cfg_set_i];
      w_cfg_ok     = cfg_wr_i && (r_state != ST_INIT) && !w_set_locked && w_addr_ok;
   end

   // Staging RAM, not reset: INIT overwrites every slot after reset.
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < 2; k++) begin
         if (r_state == ST_INIT) begin
            r_ram[k][r_cnt] <= INIT_THRESH;
         end else if (w_cfg_ok && (cfg_set_i == 1'(k))) begin
            r_ram[k][cfg_addr_i] <= cfg_data_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state  <= ST_INIT;
         r_cnt    <= '0;
         r_drain  <= 1'b0;
         r_active <= 2'b00;
         r_pend   <= 2'b00;
         r_busy   <= 1'b1;
         r_done   <= 2'b00;
         r_err    <= 1'b0;
         r_thresh <= '0;
         r_wr     <= 2'b00;
         r_upd    <= 2'b00;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_drain  <= w_drain_nxt;
         r_active <= w_active_nxt;
         r_pend   <= w_pend_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_err    <= w_err_nxt;
         r_thresh <= w_thresh_nxt;
         r_wr     <= w_wr_nxt;
         r_upd    <= w_upd_nxt;
      end
   end

   // Sequencer: r_cnt is the INIT write slot, then the slot read for the following SHIFT cycle.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_drain_nxt  = 1'b0;
      w_active_nxt = r_active;
      w_pend_nxt   = r_pend | cfg_load_i;
      w_rd_en      = 1'b0;

      case (r_state)
         ST_INIT: begin
            w_cnt_nxt = r_cnt + AW'(1);
            if (r_cnt == AW'(NSLOT - 1)) begin
               w_state_nxt  = ST_READ;
               w_cnt_nxt    = AW'(NSLOT - 1);
               w_active_nxt = 2'b11;
            end
         end
         ST_IDLE: begin
            w_active_nxt = cfg_load_i | r_pend;
            w_pend_nxt   = 2'b00;
            if (w_active_nxt != 2'b00) begin
               w_state_nxt = ST_READ;
               w_cnt_nxt   = AW'(NSLOT - 1);
            end
         end
         ST_READ: begin
            w_rd_en     = 1'b1;
            w_cnt_nxt   = r_cnt - AW'(1);
            w_drain_nxt = (r_cnt == '0);
            w_state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (r_drain) begin
               w_state_nxt = ST_UPD;
            end else begin
               w_rd_en     = 1'b1;
               w_cnt_nxt   = r_cnt - AW'(1);
               w_drain_nxt = (r_cnt == '0);
            end
         end
         ST_UPD: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_INIT;
         end
      endcase
   end

   // Next values of the registered outputs; the bus is zero for any set not shifting.
   always_comb begin
      w_busy_nxt   = (w_state_nxt != ST_IDLE);
      w_wr_nxt     = w_rd_en ? r_active : 2'b00;
      w_upd_nxt    = (w_state_nxt == ST_UPD) ? r_active : 2'b00;
      w_done_nxt   = w_upd_nxt;
      w_err_nxt    = r_err | (cfg_wr_i && !w_cfg_ok);
      w_thresh_nxt = '0;
      for (int k = 0; k < 2; k++) begin
         if (w_rd_en && r_active[k]) begin
            w_thresh_nxt[k*TBITS +: TBITS] = r_ram[k][r_cnt];
         end
      end
   end

   assign busy_o          = r_busy;
   assign done_o          = r_done;
   assign cfg_err_o       = r_err;
   assign thresh_o        = r_thresh;
   assign thresh_wr_o     = r_wr;
   assign thresh_update_o = r_upd;

endmodule
